// File: rtl/homelab_bus_pkg.sv
// rtl/homelab_bus_pkg.sv - shared types and constants for the homelab CPU bus fabric
package homelab_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_M1DLY = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } bridge_state_e;

  localparam logic [7:0] BUS_FLOAT          = 8'hFF;
  localparam logic [7:0] DEFAULT_INT_VECTOR = 8'hFF;

endpackage

// File: rtl/z80_bus_bridge.sv
// rtl/z80_bus_bridge.sv - turns Z80 bus cycles into level req/ack transactions, stretching the CPU with wait_n
module z80_bus_bridge
  import homelab_bus_pkg::*;
#(
  parameter int         M1_WAIT    = 0,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] INT_VECTOR = DEFAULT_INT_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  localparam logic [7:0] M1_LAST = 8'((M1_WAIT > 0) ? (M1_WAIT - 1) : 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bridge_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    di_q, di_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          io_q, io_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          inta, start;

  // rfsh_n qualification keeps a refresh cycle from ever looking like a start
  assign inta  = ~m1_n & ~iorq_n;
  assign start = (~rd_n | ~wr_n) & (~mreq_n | ~iorq_n) & ~inta & rfsh_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      di_q    <= BUS_FLOAT;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      di_q    <= di_d;
      req_q   <= req_d;
      we_q    <= we_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    di_d    = di_q;
    req_d   = req_q;
    we_d    = we_q;
    io_d    = io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    wait_n  = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (inta) begin
          wait_n  = 1'b0;
          di_d    = INT_VECTOR;
          state_d = ST_DONE;
        end else if (start) begin
          wait_n  = 1'b0;
          addr_d  = A;
          wdata_d = dout;
          we_d    = ~wr_n;
          io_d    = ~iorq_n;
          cnt_d   = 8'd0;
          if (~m1_n && (M1_WAIT > 0)) begin
            state_d = ST_M1DLY;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end
        end
      end
      ST_M1DLY: begin
        wait_n = 1'b0;
        if (cnt_q == M1_LAST) begin
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_REQ: begin
        wait_n = 1'b0;
        // ack is checked first so a same-cycle ack beats the timeout
        if (mem_ack) begin
          if (!we_q) di_d = mem_rdata;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q >= TO_LAST) begin
          di_d    = BUS_FLOAT;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // an interrupt ack holds iorq_n/m1_n with no rd/wr strobe, so wait for it too
        if (rd_n && wr_n && !inta) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign di        = di_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_io    = io_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb/tb_z80_bus_bridge.sv - directed self-checking bench for z80_bus_bridge
module tb_z80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        wait_n;
  logic        mem_req, mem_we, mem_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;
  int low_cnt;

  z80_bus_bridge #(
    .M1_WAIT   (2),
    .TIMEOUT   (4),
    .INT_VECTOR(8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .m1_n     (m1_n),
    .rfsh_n   (rfsh_n),
    .A        (A),
    .dout     (dout),
    .di       (di),
    .wait_n   (wait_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_io   (mem_io),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  initial begin
    bus_idle();
    A = 16'h0; dout = 8'h0; mem_ack = 1'b0; mem_rdata = 8'h0;
    reset = 1'b1;
    #1;
    check("rst_req",   mem_req,  1'b0);
    check("rst_di",    di,       8'hFF);
    check("rst_wait",  wait_n,   1'b1);
    check("rst_err",   bus_err,  1'b0);
    check("rst_addr",  mem_addr, 16'h0);
    check("rst_wdata", mem_wdata, 8'h0);
    check("rst_weio",  {mem_we, mem_io}, 2'b00);
    tick(); tick();
    reset = 1'b0;
    tick();

    // memory read, ack seen on the third edge after mem_req rises
    A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("t1_wait_first", wait_n, 1'b0);
    tick();
    check("t1_req",   mem_req,  1'b1);
    check("t1_addr",  mem_addr, 16'h1234);
    check("t1_weio",  {mem_we, mem_io}, 2'b00);
    tick();
    check("t1_req2",  mem_req, 1'b1);
    tick();
    check("t1_req3",  mem_req, 1'b1);
    check("t1_wait3", wait_n,  1'b0);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    check("t1_req_off", mem_req, 1'b0);
    check("t1_di",      di,      8'h5A);
    check("t1_wait_done", wait_n, 1'b1);
    bus_idle();
    tick();

    // IO write with ack in the same cycle mem_req rises
    A = 16'h00FE; dout = 8'hC3; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    check("t2_req",   mem_req,   1'b1);
    check("t2_weio",  {mem_we, mem_io}, 2'b11);
    check("t2_wdata", mem_wdata, 8'hC3);
    check("t2_addr",  mem_addr,  16'h00FE);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    check("t2_req_off", mem_req, 1'b0);
    check("t2_di_keep", di,      8'h5A);
    check("t2_err",     bus_err, 1'b0);
    bus_idle();
    tick();

    // interrupt acknowledge held for several cycles
    m1_n = 1'b0; iorq_n = 1'b0;
    low_cnt = 0;
    #1;
    if (!wait_n) low_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!wait_n) low_cnt++;
      check("t4_noreq", mem_req, 1'b0);
    end
    check("t4_wait_low_cycles", low_cnt, 1);
    check("t4_di", di, 8'hFF);
    bus_idle();
    tick();

    // opcode fetch with two inserted wait cycles
    A = 16'h0100; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("t3_wait0", wait_n, 1'b0);
    tick();
    check("t3_req_e1",  mem_req, 1'b0);
    check("t3_wait_e1", wait_n,  1'b0);
    tick();
    check("t3_req_e2",  mem_req, 1'b0);
    check("t3_wait_e2", wait_n,  1'b0);
    tick();
    check("t3_req_e3",  mem_req, 1'b1);
    check("t3_wait_e3", wait_n,  1'b0);
    check("t3_addr",    mem_addr, 16'h0100);
    mem_ack = 1'b1; mem_rdata = 8'h3E;
    tick();
    mem_ack = 1'b0;
    check("t3_di", di, 8'h3E);
    bus_idle();
    tick();

    // dead slave: timeout after four cycles in REQ, late ack ignored
    A = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check("t5_req_on", mem_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_req_hold", mem_req, 1'b1);
      check("t5_err_quiet", bus_err, 1'b0);
    end
    tick();
    check("t5_req_drop", mem_req, 1'b0);
    check("t5_err",      bus_err, 1'b1);
    check("t5_di",       di,      8'hFF);
    tick();
    check("t5_err_pulse", bus_err, 1'b0);
    check("t5_wait_done", wait_n,  1'b1);
    mem_ack = 1'b1; mem_rdata = 8'h42;
    tick();
    mem_ack = 1'b0;
    check("t5_late_di",  di,      8'hFF);
    check("t5_late_req", mem_req, 1'b0);
    check("t5_late_err", bus_err, 1'b0);
    bus_idle();
    tick();

    // reset in the middle of REQ
    A = 16'h4000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check("t6_req_on", mem_req, 1'b1);
    #2;
    reset = 1'b1;
    bus_idle();
    #1;
    check("t6_req_async", mem_req, 1'b0);
    check("t6_wait",      wait_n,  1'b1);
    check("t6_di",        di,      8'hFF);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    reset = 1'b0;
    tick();
    check("t6_ack_ignored_di",  di,      8'hFF);
    check("t6_ack_ignored_req", mem_req, 1'b0);
    mem_ack = 1'b0;
    A = 16'h5555; dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    check("t6_restart_req",   mem_req,   1'b1);
    check("t6_restart_addr",  mem_addr,  16'h5555);
    check("t6_restart_wdata", mem_wdata, 8'h99);
    check("t6_restart_weio",  {mem_we, mem_io}, 2'b10);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_restart_done", mem_req, 1'b0);
    bus_idle();
    tick();

    // refresh cycle must not start a transaction
    A = 16'h007F; mreq_n = 1'b0; rfsh_n = 1'b0;
    #1;
    check("rf_wait", wait_n, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rf_noreq", mem_req, 1'b0);
    end
    bus_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
